datapath: RTL and testbench
===========================

Name: datapath

Overview:
- Phase-1 32-bit CPU datapath: 16 general registers R0–R15, HI, LO, PC, IR, Y, 64-bit Z, MAR and MDR, all sharing one 32-bit bus selected by one-hot "out" strobes.
- A combinational ALU has operands A=Y and B=bus; its result is captured in Z.
- Every control strobe is driven externally by a control unit or testbench; this block holds no sequencer.

Parameters:
- WIDTH, 32, data/bus width (fixed; the design is not required to work at other values).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout  in  1 each  bus source selects.
- Read  in  1  MDR source select (1: IN, 0: bus).
- IncPC  in  1  fetch-increment control.
- AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT  in  1 each  ALU operation selects.
- R0in..R15in, HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin  in  1 each  register load enables.
- IN  in  32  memory/input data word.
- BusMuxOut  out  32  current bus value.
- PC  out  32  program counter.

Behaviour:
- All registers load on the rising clk edge when their enable is high; otherwise they hold.
- reset has priority over every load and clears all registers, including Z (64 b) and PC, to 0.
- Reset asserted mid-operation discards that cycle's loads.
- Bus source (combinational):
  - Selected register value; Zhighout → Z[63:32], Zlowout → Z[31:0].
  - INout → IN.
  - Cout → IR[18:0] sign-extended to 32 b.
  - No source asserted → 0.
  - More than one source asserted: fixed priority R0..R15, HI, LO, Zhigh, Zlow, PC, IR, MDR, IN, C, Y, MAR.
- MDR load: MDRin=1 → MDR <= (Read ? IN : bus).
- HI/LO load from Z directly, not from the bus: HIin → HI <= Z[63:32]; LOin → LO <= Z[31:0].
- Y, IR, R0–R15 load from the bus. R0 is an ordinary register.
- MAR load:
  - MARin & !IncPC → MAR <= bus.
  - MARin & IncPC → MAR <= PC (current value).
- PC load:
  - PCin & IncPC → PC <= PC+1 (wraps at 2^32).
  - PCin & !IncPC → PC <= bus.
- ALU, combinational, 64-bit result R; Zin → Z <= R.
  - AND/OR: A&B, A|B.
  - ADD/SUB: A+B, A−B, mod 2^32.
  - MUL: signed 64-bit product A×B.
  - DIV: signed, truncating toward zero. R[31:0]=quotient, R[63:32]=remainder; remainder takes the dividend's sign.
  - DIV by zero: quotient 0xFFFFFFFF, remainder = A.
  - DIV of 0x80000000 by −1: quotient 0x80000000, remainder 0.
  - SHR/SHRA/SHL: A shifted by B[4:0], logical right, arithmetic right, left.
  - ROR/ROL: A rotated by B[4:0].
  - NEG: −B. NOT: ~B.
  - Upper 32 b of R are 0 for every op except MUL and DIV.
  - No op selected → R=0.
  - Multiple ops selected: priority in port-list order (AND highest).
- Latency:
  - Bus and ALU are combinational.
  - A result is visible in Z one edge after Zin and in HI/LO one edge after HIin/LOin.

Decomposition:
- Shared package: WIDTH constant; bus-source and ALU-op index constants matching the priority orders above.
- Natural sub-module: datapath_alu (A, B, op strobes → 64-bit result).
- Registers are a generic enable/sync-reset 32-bit register instantiated per register. This generic register is not counted as a design sub-block.

Test Plan:
- Reset then fetch:
  - Stimulus: reset; then IncPC+MARin+PCin+MDRin+Read with IN=0x79300000 for one edge; then MDRout+IRin.
  - Required: PC=1, MAR=0, MDR=0x79300000, IR=0x79300000.
- DIV:
  - Stimulus: load R2=−236 and R6=17 via MDR (Read); R2out+Yin; R6out+DIV+Zin; HIin+LOin.
  - Required: LO=0xFFFFFFF3 (−13), HI=0xFFFFFFF1 (−15).
- MUL:
  - Stimulus: same operands as DIV, with MUL in place of DIV.
  - Required: LO=0xFFFFF054, HI=0xFFFFFFFF.
- ADD and C-immediate:
  - Stimulus: Y=0x28, B=17 via bus, ADD into Z.
  - Required: Zlow=0x39, Zhigh=0.
  - Stimulus: IR=0x0007FFFF with Cout.
  - Required: bus=0xFFFFFFFF.
- Shifts/rotates:
  - SHRA −236 by 2 → 0xFFFFFFC5.
  - ROL 0x80000001 by 1 → 0x00000003.
  - SHR 0x80000000 by 31 → 1.
- Edge cases:
  - DIV 5/0 → LO=0xFFFFFFFF, HI=5.
  - No out strobe → BusMuxOut=0.
  - reset asserted together with R2in → R2=0.

Source files
------------

// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_pkg
//  Description : Shared constants for the phase-1 CPU datapath: data width,
//                bus-source indices and ALU-op indices (index order is the
//                selection priority, lowest index wins).
//  Revision    : 1.0  initial release
// ============================================================================
package datapath_pkg;

    localparam int WIDTH     = 32;

    // Bus sources, in priority order
    localparam int SRC_R0    = 0;
    localparam int SRC_HI    = 16;
    localparam int SRC_LO    = 17;
    localparam int SRC_ZHI   = 18;
    localparam int SRC_ZLO   = 19;
    localparam int SRC_PC    = 20;
    localparam int SRC_IR    = 21;
    localparam int SRC_MDR   = 22;
    localparam int SRC_IN    = 23;
    localparam int SRC_C     = 24;
    localparam int SRC_Y     = 25;
    localparam int SRC_MAR   = 26;
    localparam int SRC_COUNT = 27;

    // ALU operations, in priority order
    localparam int OP_AND    = 0;
    localparam int OP_OR     = 1;
    localparam int OP_ADD    = 2;
    localparam int OP_SUB    = 3;
    localparam int OP_MUL    = 4;
    localparam int OP_DIV    = 5;
    localparam int OP_SHR    = 6;
    localparam int OP_SHRA   = 7;
    localparam int OP_SHL    = 8;
    localparam int OP_ROR    = 9;
    localparam int OP_ROL    = 10;
    localparam int OP_NEG    = 11;
    localparam int OP_NOT    = 12;
    localparam int OP_COUNT  = 13;

    // Immediate constant field of the instruction register, sign-extended
    function automatic logic [WIDTH-1:0] sext_c(input logic [WIDTH-1:0] ir);
        return {{(WIDTH-19){ir[18]}}, ir[18:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/datapath_alu.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_alu
//  Description : Combinational ALU, A = Y, B = bus, 64-bit result. Upper half
//                is only non-zero for MUL (product) and DIV (remainder).
//  Revision    : 1.0  initial release
// ============================================================================
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [WIDTH-1:0]    a_i,
    input  logic [WIDTH-1:0]    b_i,
    input  logic [OP_COUNT-1:0] op_i,
    output logic [2*WIDTH-1:0]  result_o
);

    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic [4:0]                sh;
    logic [2*WIDTH-1:0]        dbl;

    assign a_ext = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    assign b_ext = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    assign sh    = b_i[4:0];
    assign dbl   = {a_i, a_i};

    // Priority-decoded operation select, lowest op index wins
    always_comb begin
        result_o = '0;
        if (op_i[OP_AND])
            result_o[WIDTH-1:0] = a_i & b_i;
        else if (op_i[OP_OR])
            result_o[WIDTH-1:0] = a_i | b_i;
        else if (op_i[OP_ADD])
            result_o[WIDTH-1:0] = a_i + b_i;
        else if (op_i[OP_SUB])
            result_o[WIDTH-1:0] = a_i - b_i;
        else if (op_i[OP_MUL])
            result_o = a_ext * b_ext;
        else if (op_i[OP_DIV]) begin
            // Divide-by-zero and the single overflow case are fixed values;
            // everything else truncates toward zero.
            if (b_i == '0) begin
                result_o[WIDTH-1:0]       = '1;
                result_o[2*WIDTH-1:WIDTH] = a_i;
            end else if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
                result_o[WIDTH-1:0]       = 32'h8000_0000;
                result_o[2*WIDTH-1:WIDTH] = '0;
            end else begin
                result_o[WIDTH-1:0]       = $signed(a_i) / $signed(b_i);
                result_o[2*WIDTH-1:WIDTH] = $signed(a_i) % $signed(b_i);
            end
        end
        else if (op_i[OP_SHR])
            result_o[WIDTH-1:0] = a_i >> sh;
        else if (op_i[OP_SHRA])
            result_o[WIDTH-1:0] = $signed(a_i) >>> sh;
        else if (op_i[OP_SHL])
            result_o[WIDTH-1:0] = a_i << sh;
        else if (op_i[OP_ROR])
            result_o[WIDTH-1:0] = dbl[WIDTH-1:0] >> sh | dbl[2*WIDTH-1:WIDTH] << (6'd32 - {1'b0, sh});
        else if (op_i[OP_ROL])
            result_o[WIDTH-1:0] = (dbl << sh) >> WIDTH;
        else if (op_i[OP_NEG])
            result_o[WIDTH-1:0] = '0 - b_i;
        else if (op_i[OP_NOT])
            result_o[WIDTH-1:0] = ~b_i;
    end

endmodule
`default_nettype wire

// File: rtl/datapath_reg.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_reg
//  Description : Generic load-enable register with synchronous active-high
//                reset (reset wins over load).
//  Revision    : 1.0  initial release
// ============================================================================
module datapath_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] val_q;

    // Clear on reset, otherwise load when enabled
    always_ff @(posedge clk) begin
        if (reset)
            val_q <= '0;
        else if (en_i)
            val_q <= d_i;
    end

    assign q_o = val_q;

endmodule
`default_nettype wire

// File: rtl/datapath.sv
`default_nettype none
// ============================================================================
//  Module      : datapath
//  Description : Phase-1 32-bit CPU datapath. All registers share one bus
//                driven by a priority-encoded source mux; strobes come from
//                an external control unit.
//  Revision    : 1.0  initial release
// ============================================================================
module datapath
    import datapath_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic             R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic             HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout,
    input  logic             INout, Cout, Yout, MARout,
    input  logic             Read,
    input  logic             IncPC,
    input  logic             AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
    input  logic             R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  logic             R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic             HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin,
    input  logic [WIDTH-1:0] IN,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] PC
);

    logic [SRC_COUNT-1:0] sel;
    logic [15:0]          gpr_en;
    logic [OP_COUNT-1:0]  op;
    logic [WIDTH-1:0]     src   [SRC_COUNT];
    logic [WIDTH-1:0]     gpr_q [16];
    logic [WIDTH-1:0]     hi_q, lo_q, pc_q, ir_q, y_q, mar_q, mdr_q;
    logic [WIDTH-1:0]     pc_d, mar_d, mdr_d;
    logic [2*WIDTH-1:0]   z_q, alu_res;
    logic [WIDTH-1:0]     bus;

    assign sel = {MARout, Yout, Cout, INout, MDRout, IRout, PCout, Zlowout, Zhighout,
                  LOout, HIout, R15out, R14out, R13out, R12out, R11out, R10out, R9out,
                  R8out, R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign gpr_en = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign op = {NOT, NEG, ROL, ROR, SHL, SHR_A_BIT(), SHR, DIV, MUL, SUB, ADD, OR, AND};

    function automatic logic SHR_A_BIT();
        return SHRA;
    endfunction

    // General registers, loaded from the bus
    generate
        for (genvar i = 0; i < 16; i++) begin : g_gpr
            datapath_reg #(.W(WIDTH)) u_gpr (
                .clk(clk), .reset(reset), .en_i(gpr_en[i]), .d_i(bus), .q_o(gpr_q[i])
            );
            assign src[SRC_R0 + i] = gpr_q[i];
        end
    endgenerate

    assign src[SRC_HI]  = hi_q;
    assign src[SRC_LO]  = lo_q;
    assign src[SRC_ZHI] = z_q[2*WIDTH-1:WIDTH];
    assign src[SRC_ZLO] = z_q[WIDTH-1:0];
    assign src[SRC_PC]  = pc_q;
    assign src[SRC_IR]  = ir_q;
    assign src[SRC_MDR] = mdr_q;
    assign src[SRC_IN]  = IN;
    assign src[SRC_C]   = sext_c(ir_q);
    assign src[SRC_Y]   = y_q;
    assign src[SRC_MAR] = mar_q;

    // Bus mux: scan from lowest priority up so the lowest asserted index wins
    always_comb begin
        bus = '0;
        for (int i = SRC_COUNT - 1; i >= 0; i--) begin
            if (sel[i])
                bus = src[i];
        end
    end

    assign pc_d  = IncPC ? pc_q + 32'd1 : bus;
    assign mar_d = IncPC ? pc_q : bus;
    assign mdr_d = Read ? IN : bus;

    datapath_reg #(.W(WIDTH))   u_hi  (.clk(clk), .reset(reset), .en_i(HIin),  .d_i(z_q[2*WIDTH-1:WIDTH]), .q_o(hi_q));
    datapath_reg #(.W(WIDTH))   u_lo  (.clk(clk), .reset(reset), .en_i(LOin),  .d_i(z_q[WIDTH-1:0]),       .q_o(lo_q));
    datapath_reg #(.W(WIDTH))   u_pc  (.clk(clk), .reset(reset), .en_i(PCin),  .d_i(pc_d),  .q_o(pc_q));
    datapath_reg #(.W(WIDTH))   u_ir  (.clk(clk), .reset(reset), .en_i(IRin),  .d_i(bus),   .q_o(ir_q));
    datapath_reg #(.W(WIDTH))   u_y   (.clk(clk), .reset(reset), .en_i(Yin),   .d_i(bus),   .q_o(y_q));
    datapath_reg #(.W(WIDTH))   u_mar (.clk(clk), .reset(reset), .en_i(MARin), .d_i(mar_d), .q_o(mar_q));
    datapath_reg #(.W(WIDTH))   u_mdr (.clk(clk), .reset(reset), .en_i(MDRin), .d_i(mdr_d), .q_o(mdr_q));
    datapath_reg #(.W(2*WIDTH)) u_z   (.clk(clk), .reset(reset), .en_i(Zin),   .d_i(alu_res), .q_o(z_q));

    datapath_alu u_alu (
        .a_i(y_q), .b_i(bus), .op_i(op), .result_o(alu_res)
    );

    assign BusMuxOut = bus;
    assign PC        = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datapath
//  Description : Self-checking bench for the phase-1 datapath: table of ALU
//                vectors plus hand sequences for fetch, C-immediate, bus
//                priority and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rout, rin;
    logic [12:0] op;
    logic        HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout;
    logic        Read, IncPC;
    logic        HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin;
    logic [31:0] IN;
    logic [31:0] BusMuxOut, PC;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    datapath dut (
        .clk(clk), .reset(reset),
        .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
        .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
        .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCout(PCout), .IRout(IRout), .MDRout(MDRout), .INout(INout), .Cout(Cout),
        .Yout(Yout), .MARout(MARout), .Read(Read), .IncPC(IncPC),
        .AND(op[0]), .OR(op[1]), .ADD(op[2]), .SUB(op[3]), .MUL(op[4]), .DIV(op[5]),
        .SHR(op[6]), .SHRA(op[7]), .SHL(op[8]), .ROR(op[9]), .ROL(op[10]),
        .NEG(op[11]), .NOT(op[12]),
        .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
        .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
        .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Zin(Zin), .Yin(Yin),
        .MARin(MARin), .MDRin(MDRin),
        .IN(IN), .BusMuxOut(BusMuxOut), .PC(PC)
    );

    typedef struct {
        string       name;
        int          opi;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[16];

    task automatic idle();
        rout = '0; rin = '0; op = '0;
        {HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout} = '0;
        {Read, IncPC, HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin} = '0;
    endtask

    // One rising edge with the strobes currently driven, then drop them
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Caller has asserted an out strobe; let the bus settle and compare it
    task automatic sample(input string name, input logic [31:0] exp);
        #1;
        chk(name, BusMuxOut, exp);
        idle();
    endtask

    task automatic load_gpr(input int idx, input logic [31:0] v);
        IN = v; MDRin = 1'b1; Read = 1'b1;
        tick();
        MDRout = 1'b1; rin[idx] = 1'b1;
        tick();
    endtask

    initial begin
        vecs[0]  = '{"div",      5,  32'hFFFF_FF14, 32'd17,        32'hFFFF_FFF1, 32'hFFFF_FFF3};
        vecs[1]  = '{"mul",      4,  32'hFFFF_FF14, 32'd17,        32'hFFFF_FFFF, 32'hFFFF_F054};
        vecs[2]  = '{"add",      2,  32'h0000_0028, 32'd17,        32'h0,         32'h0000_0039};
        vecs[3]  = '{"shra",     7,  32'hFFFF_FF14, 32'd2,         32'h0,         32'hFFFF_FFC5};
        vecs[4]  = '{"rol",      10, 32'h8000_0001, 32'd1,         32'h0,         32'h0000_0003};
        vecs[5]  = '{"shr",      6,  32'h8000_0000, 32'd31,        32'h0,         32'h0000_0001};
        vecs[6]  = '{"div0",     5,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        vecs[7]  = '{"divovf",   5,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
        vecs[8]  = '{"sub",      3,  32'd5,         32'd7,         32'h0,         32'hFFFF_FFFE};
        vecs[9]  = '{"and",      0,  32'h0000_F0F0, 32'h0000_FF00, 32'h0,         32'h0000_F000};
        vecs[10] = '{"or",       1,  32'h0000_F0F0, 32'h0000_FF00, 32'h0,         32'h0000_FFF0};
        vecs[11] = '{"not",      12, 32'h1234_5678, 32'h0000_FFFF, 32'h0,         32'hFFFF_0000};
        vecs[12] = '{"neg",      11, 32'h1234_5678, 32'd1,         32'h0,         32'hFFFF_FFFF};
        vecs[13] = '{"shl",      8,  32'd1,         32'd36,        32'h0,         32'h0000_0010};
        vecs[14] = '{"ror",      9,  32'd1,         32'd1,         32'h0,         32'h8000_0000};
        vecs[15] = '{"mulbig",   4,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};

        IN = '0;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Reset state and empty bus
        chk("reset_pc", PC, 32'h0);
        sample("no_source_bus", 32'h0);
        Zhighout = 1'b1; sample("reset_zhigh", 32'h0);

        // Fetch: MAR <= old PC, PC <= PC+1, MDR <= IN, then IR <= MDR
        IN = 32'h7930_0000;
        IncPC = 1'b1; MARin = 1'b1; PCin = 1'b1; MDRin = 1'b1; Read = 1'b1;
        tick();
        chk("fetch_pc", PC, 32'h1);
        MARout = 1'b1; sample("fetch_mar", 32'h0);
        MDRout = 1'b1; sample("fetch_mdr", 32'h7930_0000);
        MDRout = 1'b1; IRin = 1'b1;
        tick();
        IRout = 1'b1; sample("fetch_ir", 32'h7930_0000);

        // ALU vectors: R2 -> Y, R6 -> B, result into Z, then HI/LO from Z
        foreach (vecs[i]) begin
            load_gpr(2, vecs[i].a);
            load_gpr(6, vecs[i].b);
            rout[2] = 1'b1; Yin = 1'b1;
            tick();
            rout[6] = 1'b1; op[vecs[i].opi] = 1'b1; Zin = 1'b1;
            tick();
            Zlowout = 1'b1; sample({vecs[i].name, "_zlo"}, vecs[i].lo);
            HIin = 1'b1; LOin = 1'b1;
            tick();
            HIout = 1'b1; sample({vecs[i].name, "_hi"}, vecs[i].hi);
            LOout = 1'b1; sample({vecs[i].name, "_lo"}, vecs[i].lo);
        end

        // C immediate: IR[18:0] sign-extended
        load_gpr(3, 32'h0007_FFFF);
        rout[3] = 1'b1; IRin = 1'b1;
        tick();
        Cout = 1'b1; sample("cimm_neg", 32'hFFFF_FFFF);
        load_gpr(3, 32'hFFF3_FFFF);
        rout[3] = 1'b1; IRin = 1'b1;
        tick();
        Cout = 1'b1; sample("cimm_pos", 32'h0003_FFFF);

        // Bus priority: lower-numbered source wins
        load_gpr(2, 32'hAAAA_0002);
        load_gpr(6, 32'hBBBB_0006);
        rout[2] = 1'b1; rout[6] = 1'b1; sample("prio_r2_r6", 32'hAAAA_0002);
        rout[6] = 1'b1; INout = 1'b1; IN = 32'h5555_5555; sample("prio_r6_in", 32'hBBBB_0006);

        // Load MAR from bus (no IncPC) and PC from bus
        INout = 1'b1; IN = 32'h0000_0100; MARin = 1'b1; PCin = 1'b1;
        tick();
        MARout = 1'b1; sample("mar_from_bus", 32'h0000_0100);
        chk("pc_from_bus", PC, 32'h0000_0100);

        // Reset together with a load discards the load
        INout = 1'b1; IN = 32'h0000_0055; rin[2] = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        rout[2] = 1'b1; sample("reset_beats_load", 32'h0);
        rout[6] = 1'b1; sample("reset_clears_r6", 32'h0);
        chk("reset_clears_pc", PC, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
